// File: rtl/axi_pkg.sv
// Shared AXI4 constants and helpers for the read-DMA path.
// Burst encodings, the 4 KB boundary and the scheduler state type.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam int AXI_BOUNDARY_BYTES = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } sched_state_e;

  function automatic int axi_size(input int dw);
    int s;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      if ((8 << i) == dw) s = i;
    end
    return s;
  endfunction

endpackage

// File: rtl/axi_burst_len_calc.sv
// Next burst length: min of beats left, max burst and beats to 4 KB.
// Pure combinational; addr is the 4 KB page offset.
module axi_burst_len_calc
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH    = 512,
  parameter int LEN_WIDTH     = 20,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic [11:0]          addr,
  input  logic [LEN_WIDTH-1:0] remaining,
  output logic [8:0]           beats,
  output logic [7:0]           arlen
);

  localparam int SZ = axi_size(DATA_WIDTH);
  localparam int CW = LEN_WIDTH + 14;

  logic [12:0]   to_bnd;
  logic [CW-1:0] rem_w;
  logic [CW-1:0] bnd_w;
  logic [CW-1:0] lim_w;
  logic [CW-1:0] min_w;

  always_comb begin
    to_bnd = 13'(AXI_BOUNDARY_BYTES) - {1'b0, addr};
    rem_w  = CW'(remaining);
    bnd_w  = CW'(to_bnd >> SZ);
    lim_w  = CW'(MAX_BURST_LEN);
    min_w  = rem_w;
    if (lim_w < min_w) min_w = lim_w;
    if (bnd_w < min_w) min_w = bnd_w;
  end

  assign beats = 9'(min_w);
  assign arlen = 8'(min_w - CW'(1));

endmodule

// File: rtl/axi_read_burst_scheduler.sv
// Read-DMA scheduler: splits a descriptor into INCR bursts,
// limits bursts in flight and streams R data downstream.
module axi_read_burst_scheduler
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 8,
  parameter int AXI_ID          = 0,
  parameter int LEN_WIDTH       = 20,
  parameter int MAX_BURST_LEN   = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_beats,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int SZ = axi_size(DATA_WIDTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH-1:0] AMASK =
    ~ADDR_WIDTH'((1 << SZ) - 1);
  localparam logic [OW-1:0] OMAX = OW'(MAX_OUTSTANDING);

  sched_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  issue_rem_q;
  logic [LEN_WIDTH-1:0]  data_rem_q;
  logic [OW-1:0]         outst_q;
  logic                  arvalid_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]            arlen_q;
  logic [8:0]            burst_q;
  logic                  err_q;
  logic                  zdone_q;

  logic [8:0]           calc_beats;
  logic [7:0]           calc_len;
  logic [LEN_WIDTH-1:0] burst_len;
  logic cmd_hs, ar_hs, r_hs, rl_hs;
  logic can_issue, drain_ok;
  logic unused_rid;

  axi_burst_len_calc #(
    .DATA_WIDTH    (DATA_WIDTH),
    .LEN_WIDTH     (LEN_WIDTH),
    .MAX_BURST_LEN (MAX_BURST_LEN)
  ) u_len (
    .addr      (addr_q[11:0]),
    .remaining (issue_rem_q),
    .beats     (calc_beats),
    .arlen     (calc_len)
  );

  assign unused_rid = ^m_axi_rid;

  assign busy         = state_q != ST_IDLE;
  assign cmd_ready    = state_q == ST_IDLE && !rst;
  assign m_axi_rready = out_ready & busy;
  assign out_valid    = m_axi_rvalid & busy;
  assign out_data     = m_axi_rdata;
  assign out_last     = out_valid &&
                        data_rem_q == LEN_WIDTH'(1);
  assign err          = err_q;

  assign m_axi_arid    = ID_WIDTH'(AXI_ID);
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'(SZ);
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;

  assign cmd_hs    = cmd_valid & cmd_ready;
  assign ar_hs     = arvalid_q & m_axi_arready;
  assign r_hs      = m_axi_rvalid & m_axi_rready;
  assign rl_hs     = r_hs & m_axi_rlast;
  assign burst_len = LEN_WIDTH'(burst_q);

  // A new AR is only staged once the previous one has handshaken.
  assign can_issue = state_q == ST_ISSUE && !arvalid_q &&
                     issue_rem_q != '0 && outst_q < OMAX;
  assign drain_ok  = state_q == ST_DRAIN &&
                     data_rem_q == '0 && outst_q == '0;
  assign done      = drain_ok | zdone_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (cmd_hs && cmd_beats != '0) state_d = ST_ISSUE;
      ST_ISSUE:
        if (ar_hs && issue_rem_q == burst_len)
          state_d = ST_DRAIN;
      ST_DRAIN:
        if (drain_ok) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      issue_rem_q <= '0;
      data_rem_q  <= '0;
      outst_q     <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      burst_q     <= '0;
      err_q       <= 1'b0;
      zdone_q     <= 1'b0;
    end else begin
      zdone_q <= cmd_hs && cmd_beats == '0;
      if (cmd_hs) begin
        addr_q      <= cmd_addr & AMASK;
        issue_rem_q <= cmd_beats;
        data_rem_q  <= cmd_beats;
        err_q       <= 1'b0;
      end
      if (can_issue) begin
        arvalid_q <= 1'b1;
        araddr_q  <= addr_q;
        arlen_q   <= calc_len;
        burst_q   <= calc_beats;
      end else if (ar_hs) begin
        arvalid_q   <= 1'b0;
        addr_q      <= addr_q + (ADDR_WIDTH'(burst_q) << SZ);
        issue_rem_q <= issue_rem_q - burst_len;
      end
      if (r_hs && data_rem_q != '0)
        data_rem_q <= data_rem_q - LEN_WIDTH'(1);
      if (r_hs && m_axi_rresp != 2'b00)
        err_q <= 1'b1;
      unique case ({ar_hs, rl_hs})
        2'b10:   outst_q <= outst_q + OW'(1);
        2'b01:   outst_q <= outst_q - OW'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_burst_scheduler.sv
// Directed bench for axi_read_burst_scheduler with a small
// AXI read memory model and hand-computed AR/beat expectations.
module tb_axi_read_burst_scheduler;

  localparam int DW = 512;
  localparam int AW = 32;
  localparam int IW = 8;
  localparam int LW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_beats;
  logic [IW-1:0] m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arlock;
  logic [3:0]    m_axi_arcache;
  logic [2:0]    m_axi_arprot;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [IW-1:0] m_axi_rid;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          err;

  axi_read_burst_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_beats     (cmd_beats),
    .m_axi_arid    (m_axi_arid),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arlock  (m_axi_arlock),
    .m_axi_arcache (m_axi_arcache),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rid     (m_axi_rid),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    int          len;
  } burst_t;

  burst_t      mq[$];
  logic [31:0] exp_addr[$];
  logic [7:0]  exp_len[$];
  int          r_beat = 0;
  int          beat_idx = 0;
  int          beats_total = 0;
  logic [31:0] data_base = '0;
  int          ar_cnt = 0;
  int          r_cnt = 0;
  int          outst = 0;
  int          max_outst = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          last_cyc = 0;
  int          done_cyc = 0;
  bit          rand_mode = 1'b0;
  int          rv_pct = 100;
  logic [1:0]  resp_val = 2'b00;
  bit          chk_rready = 1'b0;
  bit          hold_pend = 1'b0;
  logic [31:0] hold_addr = '0;
  logic [7:0]  hold_len = '0;
  bit          r_hs_prev = 1'b0;

  localparam logic [20:0] AR_FIX =
    {8'h00, 3'd6, 2'b01, 4'b0011, 1'b0, 3'b000};

  task automatic observe();
    if (hold_pend) begin
      chk("ar_hold_valid", 64'(m_axi_arvalid), 64'(1));
      chk("ar_hold_addr", 64'(m_axi_araddr), 64'(hold_addr));
      chk("ar_hold_len", 64'(m_axi_arlen), 64'(hold_len));
      hold_pend = 1'b0;
    end
    if (m_axi_arvalid) begin
      if (m_axi_arready) begin
        ar_cnt++;
        outst++;
        if (exp_addr.size() > 0) begin
          chk("araddr", 64'(m_axi_araddr), 64'(exp_addr.pop_front()));
          chk("arlen", 64'(m_axi_arlen), 64'(exp_len.pop_front()));
        end else begin
          chk("ar_extra", 64'(1), 64'(0));
        end
        chk("ar_fixed",
            64'({m_axi_arid, m_axi_arsize, m_axi_arburst,
                 m_axi_arcache, m_axi_arlock, m_axi_arprot}),
            64'(AR_FIX));
        mq.push_back('{m_axi_araddr, int'(m_axi_arlen) + 1});
      end else begin
        hold_pend = 1'b1;
        hold_addr = m_axi_araddr;
        hold_len  = m_axi_arlen;
      end
    end
    if (m_axi_rvalid && m_axi_rready) begin
      chk("rdata", out_data[63:0],
          {2{data_base + 32'(beat_idx * 64)}});
      chk("out_last", 64'(out_last),
          64'(beat_idx == beats_total - 1));
      beat_idx++;
      r_cnt++;
      last_cyc = cyc;
      if (m_axi_rlast) begin
        outst--;
        r_beat = 0;
        if (mq.size() > 0) void'(mq.pop_front());
      end else begin
        r_beat++;
      end
    end
    if (outst > max_outst) max_outst = outst;
    if (chk_rready)
      chk("rready", 64'(m_axi_rready), 64'(out_ready));
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  initial begin
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rlast   = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    m_axi_rid     = '0;
    out_ready     = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        mq.delete();
        r_beat       = 0;
        outst        = 0;
        hold_pend    = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
      end else if (!(m_axi_rvalid && !r_hs_prev)) begin
        if (mq.size() > 0 && $urandom_range(99) < rv_pct) begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = {16{mq[0].addr + 32'(r_beat * 64)}};
          m_axi_rlast  = r_beat == mq[0].len - 1;
          m_axi_rresp  = resp_val;
        end else begin
          m_axi_rvalid = 1'b0;
          m_axi_rlast  = 1'b0;
        end
      end
      m_axi_arready = rand_mode ? 1'($urandom_range(1)) : 1'b1;
      out_ready     = rand_mode ? 1'($urandom_range(1)) : 1'b1;
      #1;
      r_hs_prev = m_axi_rvalid && m_axi_rready;
      if (!rst) observe();
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic setup(input logic [31:0] base, input int n);
    beat_idx    = 0;
    beats_total = n;
    data_base   = base;
    ar_cnt      = 0;
    r_cnt       = 0;
    max_outst   = 0;
    exp_addr.delete();
    exp_len.delete();
  endtask

  task automatic expect_ar(input logic [31:0] a, input logic [7:0] l);
    exp_addr.push_back(a);
    exp_len.push_back(l);
  endtask

  task automatic send(input logic [31:0] a, input int n);
    int k;
    k = 0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_beats = LW'(n);
    while (!cmd_ready && k < 50) begin
      tick();
      k++;
    end
    if (k == 50) chk("cmd_accept_timeout", 64'(0), 64'(1));
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    int d0;
    k  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && k < budget) begin
      tick();
      k++;
    end
    if (k == budget) chk("done_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_beats = '0;
    repeat (3) tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_arvalid", 64'(m_axi_arvalid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_rready", 64'(m_axi_rready), 64'(0));
    rst = 1'b0;
    tick();
    chk("idle_cmd_ready", 64'(cmd_ready), 64'(1));

    setup(32'h1000, 4);
    expect_ar(32'h1000, 8'd3);
    send(32'h1000, 4);
    wait_done(200);
    chk("t1_ars", 64'(ar_cnt), 64'(1));
    chk("t1_beats", 64'(r_cnt), 64'(4));
    chk("t1_done_lat", 64'(done_cyc - last_cyc), 64'(1));
    chk("t1_busy_at_done", 64'(busy), 64'(1));
    tick();
    chk("t1_busy_after", 64'(busy), 64'(0));
    chk("t1_done_pulse", 64'(done), 64'(0));

    setup(32'h0, 40);
    expect_ar(32'h000, 8'd15);
    expect_ar(32'h400, 8'd15);
    expect_ar(32'h800, 8'd7);
    send(32'h0, 40);
    wait_done(400);
    chk("t2_ars", 64'(ar_cnt), 64'(3));
    chk("t2_beats", 64'(r_cnt), 64'(40));

    setup(32'hFC0, 4);
    expect_ar(32'hFC0, 8'd0);
    expect_ar(32'h1000, 8'd2);
    send(32'hFC0, 4);
    wait_done(200);
    chk("t3_ars", 64'(ar_cnt), 64'(2));
    chk("t3_beats", 64'(r_cnt), 64'(4));

    rand_mode = 1'b1;
    rv_pct    = 30;
    setup(32'h2000, 128);
    for (int i = 0; i < 8; i++)
      expect_ar(32'h2000 + 32'(i * 32'h400), 8'd15);
    send(32'h2000, 128);
    chk_rready = 1'b1;
    wait_done(20000);
    chk_rready = 1'b0;
    chk("t4_ars", 64'(ar_cnt), 64'(8));
    chk("t4_beats", 64'(r_cnt), 64'(128));
    chk("t4_max_outst_ok", 64'(max_outst <= 4), 64'(1));
    rand_mode = 1'b0;
    rv_pct    = 100;
    tick();

    setup(32'h40, 0);
    send(32'h40, 0);
    chk("t5_done", 64'(done), 64'(1));
    chk("t5_busy", 64'(busy), 64'(0));
    tick();
    chk("t5_done_pulse", 64'(done), 64'(0));
    chk("t5_busy2", 64'(busy), 64'(0));
    chk("t5_no_ar", 64'(ar_cnt), 64'(0));

    resp_val = 2'b10;
    setup(32'h3000, 4);
    expect_ar(32'h3000, 8'd3);
    send(32'h3000, 4);
    wait_done(200);
    resp_val = 2'b00;
    chk("t6_err_set", 64'(err), 64'(1));
    repeat (3) tick();
    chk("t6_err_sticky", 64'(err), 64'(1));
    setup(32'h3100, 2);
    expect_ar(32'h3100, 8'd1);
    send(32'h3100, 2);
    chk("t6_err_clear", 64'(err), 64'(0));
    wait_done(200);
    chk("t6_err_ok", 64'(err), 64'(0));
    chk("t6_beats", 64'(r_cnt), 64'(2));
    tick();

    setup(32'h0, 40);
    expect_ar(32'h000, 8'd15);
    expect_ar(32'h400, 8'd15);
    expect_ar(32'h800, 8'd7);
    send(32'h0, 40);
    begin
      int k;
      k = 0;
      while (r_cnt < 20 && k < 400) begin
        tick();
        k++;
      end
      if (k == 400) chk("t7_mid_timeout", 64'(0), 64'(1));
    end
    rst = 1'b1;
    tick();
    chk("t7_arvalid", 64'(m_axi_arvalid), 64'(0));
    chk("t7_rready", 64'(m_axi_rready), 64'(0));
    chk("t7_busy", 64'(busy), 64'(0));
    chk("t7_cmd_ready_rst", 64'(cmd_ready), 64'(0));
    rst = 1'b0;
    tick();
    chk("t7_cmd_ready", 64'(cmd_ready), 64'(1));
    setup(32'h5000, 4);
    expect_ar(32'h5000, 8'd3);
    send(32'h5000, 4);
    wait_done(200);
    chk("t7_ars", 64'(ar_cnt), 64'(1));
    chk("t7_beats", 64'(r_cnt), 64'(4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_read_burst_scheduler.md
Name: axi_read_burst_scheduler

Overview:
- Read-DMA controller in front of the shared AXI4 memory read channel (512-bit data).
- Accepts one descriptor at a time (start address, beat count) and splits it into INCR bursts.
- Each burst is at most MAX_BURST_LEN beats and never crosses a 4 KB boundary.
- Keeps up to MAX_OUTSTANDING bursts in flight and forwards read data as a valid/ready stream to the accelerator datapath, with last and done signalling.

Parameters:
- DATA_WIDTH, 512, AXI data width in bits (power of two, at least 8).
- ADDR_WIDTH, 32, AXI address width.
- ID_WIDTH, 8, AXI ID width.
- AXI_ID, 0, constant ARID driven on every burst.
- LEN_WIDTH, 20, width of the descriptor beat count.
- MAX_BURST_LEN, 16, maximum beats per burst (1..256).
- MAX_OUTSTANDING, 4, maximum ARs issued whose RLAST has not yet been received (at least 1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  descriptor valid.
- cmd_ready  out  1  descriptor accepted when high together with cmd_valid.
- cmd_addr  in  ADDR_WIDTH  start byte address; low log2(DATA_WIDTH/8) bits are ignored and forced to 0.
- cmd_beats  in  LEN_WIDTH  number of data beats to read.
- m_axi_arid  out  ID_WIDTH  always AXI_ID.
- m_axi_araddr  out  ADDR_WIDTH  burst start address.
- m_axi_arlen  out  8  burst beats minus 1.
- m_axi_arsize  out  3  log2(DATA_WIDTH/8).
- m_axi_arburst  out  2  2'b01 (INCR).
- m_axi_arlock  out  1  0.
- m_axi_arcache  out  4  4'b0011.
- m_axi_arprot  out  3  0.
- m_axi_arvalid  out  1  AR valid.
- m_axi_arready  in  1  AR ready.
- m_axi_rid  in  ID_WIDTH  ignored.
- m_axi_rdata  in  DATA_WIDTH  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rlast  in  1  last beat of a burst.
- m_axi_rvalid  in  1  R valid.
- m_axi_rready  out  1  R ready.
- out_data  out  DATA_WIDTH  equals m_axi_rdata.
- out_valid  out  1  equals m_axi_rvalid while a command is active.
- out_ready  in  1  downstream ready.
- out_last  out  1  final beat of the whole descriptor.
- busy  out  1  a command is active.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  sticky; set by any RRESP != 0; cleared on the next cmd accept or by rst.

Behaviour:
- Reset values: cmd_ready=0 for the reset cycle, then 1 in IDLE. arvalid=0, busy=0, done=0, err=0, out_last=0. All counters are 0.
- State IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready with cmd_beats!=0: latch addr, set issue_remaining=cmd_beats and data_remaining=cmd_beats, go to ISSUE.
  - cmd_beats==0: accept, pulse done the next cycle, stay IDLE, no AR issued.
- State ISSUE:
  - burst = min(issue_remaining, MAX_BURST_LEN, (4096 - addr[11:0]) / (DATA_WIDTH/8)).
  - Present a registered AR (arvalid=1) only when outstanding < MAX_OUTSTANDING.
  - While arvalid=1 and arready=0, all AR fields are held stable.
  - On the AR handshake: addr += burst*(DATA_WIDTH/8), issue_remaining -= burst, outstanding += 1.
  - When issue_remaining reaches 0, go to DRAIN.
- State DRAIN:
  - Wait until data_remaining==0 and outstanding==0.
  - Then pulse done for 1 cycle, drop busy the same cycle, return to IDLE. A new cmd may be accepted the following cycle.
- R path:
  - Combinational pass-through: m_axi_rready=out_ready & busy; out_valid=m_axi_rvalid & busy.
  - Zero latency, no buffering.
- Each R handshake decrements data_remaining.
- out_last=1 when data_remaining==1 and out_valid=1.
- An R handshake with rlast decrements outstanding.
- Same-cycle AR handshake and rlast handshake: outstanding is unchanged.
- Outstanding counter width is clog2(MAX_OUTSTANDING+1). It never exceeds MAX_OUTSTANDING.
- busy=1 from the cycle after accept until the done cycle inclusive.
- The 4 KB split applies at any alignment. Address wrap beyond 2^ADDR_WIDTH is not handled; callers must not issue such descriptors.
- rst mid-operation: returns to IDLE on the next edge and drops arvalid and rready. In-flight data is discarded; the memory/interconnect is reset alongside.

Decomposition:
- Shared package axi_pkg:
  - AXI_BURST_INCR and AXI_BURST_FIXED constants.
  - AXI_BOUNDARY_BYTES=4096.
  - Function axi_size(DATA_WIDTH).
- Sub-module axi_burst_len_calc (combinational):
  - Inputs: addr, remaining.
  - Outputs: burst beats and arlen.
  - Computes the three-way minimum.
  - Instantiated once; unit-tested standalone.

Test Plan:
- Single command: cmd_addr=0x1000, beats=4, out_ready=1. Expect:
  - One AR with araddr=0x1000, arlen=3, arsize=6, arburst=1.
  - 4 out beats, out_last on beat 4.
  - done pulse 1 cycle after the last beat.
- Burst split: addr=0x0, beats=40, MAX_BURST_LEN=16. Expect three ARs:
  - 0x000 with arlen=15.
  - 0x400 with arlen=15.
  - 0x800 with arlen=7.
  - Then 40 beats with out_last only on beat 40.
- 4 KB crossing: addr=0xFC0, beats=4. Expect two ARs:
  - 0xFC0 with arlen=0.
  - 0x1000 with arlen=2.
- Backpressure and outstanding limit:
  - Stimulus: beats=128, MAX_OUTSTANDING=4, random out_ready (50%), random arready stalls.
  - Outstanding never exceeds 4.
  - AR fields stay stable while stalled.
  - Data order matches memory.
  - rready equals out_ready.
- Edge commands:
  - beats=0: done pulses, no AR, busy stays 0.
  - A burst with rresp=2'b10 sets err, which stays set until the next cmd accept.
- Reset mid-burst: assert rst during the second burst of a 40-beat command. Expect:
  - Next cycle arvalid=0, rready=0, busy=0, IDLE.
  - A new 4-beat command after reset completes normally.
